// File: rtl/radiant_trig_pkg.sv
// Shared constants, FSM state type and window-length helper for the RADIANT coincidence trigger.
package radiant_trig_pkg;

    localparam int WIN_FIELD_W = 5;
    localparam int WIN_FIELDS  = 4;
    localparam int WIN_OFFSET  = 7;
    localparam int WIN_LEN_W   = 8;

    typedef enum logic [1:0] {ARMED, FIRE, HOLD} coinc_state_t;

    // Sum of the four window subfields plus the fixed offset; max 4*31+7 = 131 fits 8 bits.
    function automatic logic [WIN_LEN_W-1:0] win_sum(input logic [WIN_FIELD_W*WIN_FIELDS-1:0] w);
        logic [WIN_LEN_W-1:0] s;
        s = WIN_LEN_W'(WIN_OFFSET);
        for (int i = 0; i < WIN_FIELDS; i++)
            s = s + WIN_LEN_W'(w[i*WIN_FIELD_W +: WIN_FIELD_W]);
        return s;
    endfunction

endpackage

// File: rtl/radiant_coinc_oneshot.sv
// One channel: rising-edge detect that (re)loads a saturating down-counter; active while nonzero.
module radiant_coinc_oneshot
    import radiant_trig_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hit,
    input  logic [WIN_LEN_W-1:0] win_len,
    output logic                 active
);

    logic                 hit_q;
    logic [WIN_LEN_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q <= 1'b0;
            cnt   <= '0;
        end else begin
            hit_q <= hit;
            if (hit && !hit_q)
                cnt <= win_len;
            else if (cnt != '0)
                cnt <= cnt - WIN_LEN_W'(1);
        end
    end

    assign active = (cnt != '0);

endmodule

// File: rtl/radiant_coinc_trig.sv
// Coincidence trigger for one RADIANT trigger: per-channel oneshots, registered popcount, ARMED/FIRE/HOLD FSM.
// Define RADIANT_COINC_SCALER_EN to add the 32-bit trig_count_o FIRE-entry scaler.
module radiant_coinc_trig
    import radiant_trig_pkg::*;
#(
    parameter int NUM_CH        = 24,
    parameter int ONESHOT_WIDTH = 20,
    parameter int THRESH_WIDTH  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            trig_i,
    input  logic                         trig_en_i,
    input  logic [NUM_CH-1:0]            trig_maskb_i,
    input  logic [ONESHOT_WIDTH-1:0]     trig_window_i,
    input  logic [THRESH_WIDTH-1:0]      trig_thresh_i,
    output logic                         trig_o,
    output logic                         trig_busy_o,
    output logic [$clog2(NUM_CH+1)-1:0]  coinc_cnt_o
`ifdef RADIANT_COINC_SCALER_EN
    ,
    output logic [31:0]                  trig_count_o
`endif
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int CMP_W = (CNT_W > THRESH_WIDTH) ? CNT_W : THRESH_WIDTH;

    logic [WIN_LEN_W-1:0] win_len;
    logic [NUM_CH-1:0]    active;
    logic [NUM_CH-1:0]    act;
    logic [CNT_W-1:0]     pop;
    logic [CMP_W-1:0]     cnt_ext, thr_ext;
    coinc_state_t         state, state_nxt;

    // Window length only tracks the register field while disabled, so it never moves mid-run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            win_len <= WIN_LEN_W'(WIN_OFFSET);
        else if (!trig_en_i)
            win_len <= win_sum(trig_window_i[WIN_FIELD_W*WIN_FIELDS-1:0]);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        radiant_coinc_oneshot u_os (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .hit     (trig_i[c]),
            .win_len (win_len),
            .active  (active[c])
        );
    end

    assign act = active & trig_maskb_i;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++)
            pop = pop + CNT_W'(act[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            coinc_cnt_o <= '0;
        else
            coinc_cnt_o <= pop;
    end

    assign cnt_ext = CMP_W'(coinc_cnt_o);
    assign thr_ext = CMP_W'(trig_thresh_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= ARMED;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        trig_o      = 1'b0;
        trig_busy_o = 1'b0;
        case (state)
            ARMED: if (thr_ext != '0 && cnt_ext >= thr_ext) state_nxt = FIRE;
            FIRE: begin
                state_nxt   = HOLD;
                trig_o      = trig_en_i;
                trig_busy_o = 1'b1;
            end
            HOLD: begin
                trig_busy_o = 1'b1;
                if (cnt_ext < thr_ext) state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
        if (!trig_en_i)
            state_nxt = ARMED;
    end

`ifdef RADIANT_COINC_SCALER_EN
    logic en_q;
    logic fire_entry;

    assign fire_entry = (state_nxt == FIRE) && (state != FIRE);

    // An enable rising edge restarts the count, but still counts a FIRE entry in that same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q         <= 1'b0;
            trig_count_o <= '0;
        end else begin
            en_q <= trig_en_i;
            if (trig_en_i && !en_q)
                trig_count_o <= 32'(fire_entry);
            else if (fire_entry && trig_count_o != '1)
                trig_count_o <= trig_count_o + 32'd1;
        end
    end
`else
    // No scaler: FIRE entries are not counted.
`endif

endmodule

// File: tb/tb_radiant_coinc_trig.sv
// Directed bench for radiant_coinc_trig: window sum, coincidence, mask, thresholds, enable/re-arm, reset.
module tb_radiant_coinc_trig;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] trig;
    logic        en;
    logic [23:0] maskb;
    logic [19:0] window;
    logic [4:0]  thresh;
    logic        trig_o;
    logic        busy;
    logic [4:0]  coinc_cnt;
`ifdef RADIANT_COINC_SCALER_EN
    logic [31:0] trig_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    radiant_coinc_trig dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .trig_i        (trig),
        .trig_en_i     (en),
        .trig_maskb_i  (maskb),
        .trig_window_i (window),
        .trig_thresh_i (thresh),
        .trig_o        (trig_o),
        .trig_busy_o   (busy),
        .coinc_cnt_o   (coinc_cnt)
`ifdef RADIANT_COINC_SCALER_EN
        ,
        .trig_count_o  (trig_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program config while disabled so win_len picks up the window, then enable.
    task automatic configure(input logic [19:0] w, input logic [23:0] m, input logic [4:0] th);
        en     = 1'b0;
        window = w;
        maskb  = m;
        thresh = th;
        trig   = '0;
        tick();
        tick();
        en = 1'b1;
        tick();
    endtask

    // Pulse p0 at cycle 0 and p1 at cycle t1; record observed behaviour per cycle.
    task automatic run(input logic [23:0] p0, input int t1, input logic [23:0] p1, input int ncyc,
                       output int fires, output int fire_t, output int busy_last,
                       output int cnt_at2, output int cnt_cycles, output int cnt_max);
        fires = 0; fire_t = -1; busy_last = -1; cnt_at2 = -1; cnt_cycles = 0; cnt_max = 0;
        for (int t = 0; t < ncyc; t++) begin
            trig = ((t == 0) ? p0 : 24'd0) | ((t == t1) ? p1 : 24'd0);
            if (trig_o === 1'b1) begin
                fires++;
                if (fire_t < 0) fire_t = t;
            end
            if (busy === 1'b1) busy_last = t;
            if (t == 2) cnt_at2 = int'(coinc_cnt);
            if (coinc_cnt != 5'd0) cnt_cycles++;
            if (int'(coinc_cnt) > cnt_max) cnt_max = int'(coinc_cnt);
            tick();
        end
        trig = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig = '0; en = 1'b0; maskb = '0; window = '0; thresh = '0;
        #2;
        n_total++; if (trig_o !== 1'b0) $display("FAIL reset_trig_o got=%b exp=0", trig_o); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (coinc_cnt !== 5'd0) $display("FAIL reset_cnt got=%0d exp=0", coinc_cnt); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_window();
        int f, ft, bl, c2, cc, cm;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'h000001, 5'd1);
        run(24'h000001, -1, 24'd0, 30, f, ft, bl, c2, cc, cm);
        n_total++; if (f !== 1) $display("FAIL win_fires got=%0d exp=1", f); else n_pass++;
        n_total++; if (ft !== 3) $display("FAIL win_fire_cycle got=%0d exp=3", ft); else n_pass++;
        n_total++; if (cc !== 17) $display("FAIL win_active_len got=%0d exp=17", cc); else n_pass++;
        n_total++; if (c2 !== 1) $display("FAIL win_cnt_at2 got=%0d exp=1", c2); else n_pass++;
        n_total++; if (bl !== 19) $display("FAIL win_busy_last got=%0d exp=19", bl); else n_pass++;
    endtask

    task automatic test_two_fold();
        int f, ft, bl, c2, cc, cm;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'h000021, 5'd2);
        run(24'h000001, 10, 24'h000020, 40, f, ft, bl, c2, cc, cm);
        n_total++; if (f !== 1) $display("FAIL two_fold_fires got=%0d exp=1", f); else n_pass++;
        n_total++; if (ft !== 13) $display("FAIL two_fold_fire_cycle got=%0d exp=13", ft); else n_pass++;
        n_total++; if (bl !== 19) $display("FAIL two_fold_busy_last got=%0d exp=19", bl); else n_pass++;
        run(24'h000001, 20, 24'h000020, 45, f, ft, bl, c2, cc, cm);
        n_total++; if (f !== 0) $display("FAIL two_fold_apart_fires got=%0d exp=0", f); else n_pass++;
    endtask

    task automatic test_mask();
        int f, ft, bl, c2, cc, cm;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'h000008, 5'd2);
        run(24'h000018, -1, 24'd0, 30, f, ft, bl, c2, cc, cm);
        n_total++; if (c2 !== 1) $display("FAIL mask_cnt got=%0d exp=1", c2); else n_pass++;
        n_total++; if (cm !== 1) $display("FAIL mask_cnt_max got=%0d exp=1", cm); else n_pass++;
        n_total++; if (f !== 0) $display("FAIL mask_fires got=%0d exp=0", f); else n_pass++;
    endtask

    task automatic test_thresh();
        int f, ft, bl, c2, cc, cm;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'hFFFFFF, 5'd0);
        run(24'hFFFFFF, -1, 24'd0, 30, f, ft, bl, c2, cc, cm);
        n_total++; if (c2 !== 24) $display("FAIL th0_cnt got=%0d exp=24", c2); else n_pass++;
        n_total++; if (f !== 0) $display("FAIL th0_fires got=%0d exp=0", f); else n_pass++;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'hFFFFFF, 5'd24);
        run(24'hFFFFFF, -1, 24'd0, 30, f, ft, bl, c2, cc, cm);
        n_total++; if (c2 !== 24) $display("FAIL th24_cnt got=%0d exp=24", c2); else n_pass++;
        n_total++; if (f !== 1) $display("FAIL th24_fires got=%0d exp=1", f); else n_pass++;
        n_total++; if (ft !== 3) $display("FAIL th24_fire_cycle got=%0d exp=3", ft); else n_pass++;
    endtask

    task automatic test_enable_rearm();
        configure({5'd31, 5'd31, 5'd31, 5'd31}, 24'h000001, 5'd1);
        for (int t = 0; t <= 20; t++) begin
            trig = (t == 0) ? 24'h000001 : 24'd0;
            en   = (t == 10) ? 1'b0 : 1'b1;
            if (t == 3) begin
                n_total++; if (trig_o !== 1'b1) $display("FAIL en_first_fire got=%b exp=1", trig_o); else n_pass++;
            end
            if (t == 10) begin
                n_total++; if (busy !== 1'b1) $display("FAIL en_hold_busy got=%b exp=1", busy); else n_pass++;
            end
            if (t == 11) begin
                n_total++; if (busy !== 1'b0) $display("FAIL en_busy_clear got=%b exp=0", busy); else n_pass++;
                n_total++; if (trig_o !== 1'b0) $display("FAIL en_armed_trig got=%b exp=0", trig_o); else n_pass++;
            end
            if (t == 12) begin
                n_total++; if (trig_o !== 1'b1) $display("FAIL en_refire got=%b exp=1", trig_o); else n_pass++;
            end
            tick();
        end
    endtask

    // Follows test_enable_rearm: still in HOLD with ch0 active on a 131-cycle window.
    task automatic test_reset_mid();
        int f;
        n_total++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got=%b exp=1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (coinc_cnt !== 5'd0) $display("FAIL rst_mid_cnt got=%0d exp=0", coinc_cnt); else n_pass++;
        n_total++; if (trig_o !== 1'b0) $display("FAIL rst_mid_trig got=%b exp=0", trig_o); else n_pass++;
        tick();
        rst_n = 1'b1;
        f = 0;
        for (int t = 0; t < 10; t++) begin
            if (trig_o === 1'b1 || coinc_cnt != 5'd0) f++;
            tick();
        end
        n_total++; if (f !== 0) $display("FAIL rst_release_activity got=%0d exp=0", f); else n_pass++;
    endtask

`ifdef RADIANT_COINC_SCALER_EN
    task automatic test_scaler();
        int f, ft, bl, c2, cc, cm;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'h000001, 5'd1);
        n_total++; if (trig_count !== 32'd0) $display("FAIL scaler_start got=%0d exp=0", trig_count); else n_pass++;
        for (int k = 0; k < 5; k++)
            run(24'h000001, -1, 24'd0, 30, f, ft, bl, c2, cc, cm);
        n_total++; if (trig_count !== 32'd5) $display("FAIL scaler_count got=%0d exp=5", trig_count); else n_pass++;
        configure({5'd4, 5'd3, 5'd2, 5'd1}, 24'h000001, 5'd1);
        n_total++; if (trig_count !== 32'd0) $display("FAIL scaler_en_clear got=%0d exp=0", trig_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_window();
        test_two_fold();
        test_mask();
        test_thresh();
        test_enable_rearm();
        test_reset_mid();
`ifdef RADIANT_COINC_SCALER_EN
        test_scaler();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
